// File: rtl/fs_sector_cache_if.sv
// Requester word port plus block-device command/stream port of fs_sector_cache.
// fsSync exists only when FS_SECTOR_SYNC_EN is defined.
interface fs_sector_cache_if #(
  parameter int width = 32
);
  logic             fsAccess;
  logic             fsRden;
  logic             fsWren;
  logic             fsMeta;
  logic [31:0]      fsAddress;
  logic [width-1:0] fsData;
  logic [width-1:0] fsQ;
  logic             fsBusy;
  logic             blkReq;
  logic             blkWrite;
  logic [31:0]      blkLba;
  logic             blkAck;
  logic [width-1:0] blkWrData;
  logic             blkWrReady;
  logic [width-1:0] blkRdData;
  logic             blkRdValid;
  logic             blkDone;
`ifdef FS_SECTOR_SYNC_EN
  logic             fsSync;
`endif

  // Cache side of the port.
  modport slave (
    input  fsAccess, fsRden, fsWren, fsMeta, fsAddress, fsData,
    output fsQ, fsBusy,
    output blkReq, blkWrite, blkLba, blkWrData,
    input  blkAck, blkWrReady, blkRdData, blkRdValid, blkDone
`ifdef FS_SECTOR_SYNC_EN
    , input fsSync
`endif
  );

  // Requester and block device side of the port.
  modport master (
    output fsAccess, fsRden, fsWren, fsMeta, fsAddress, fsData,
    input  fsQ, fsBusy,
    input  blkReq, blkWrite, blkLba, blkWrData,
    output blkAck, blkWrReady, blkRdData, blkRdValid, blkDone
`ifdef FS_SECTOR_SYNC_EN
    , output fsSync
`endif
  );
endinterface

// File: rtl/fs_sector_cache.sv
// Single-sector write-back cache between the paged memory controller and a block device.
// Define FS_SECTOR_SYNC_EN to add the fsSync write-back request.
module fs_sector_cache #(
  parameter int          width      = 32,
  parameter int          sectorbits = 7,
  parameter logic [31:0] METABASE   = 32'h0010_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  fs_sector_cache_if.slave  bus
);

  localparam int depth = 1 << sectorbits;
  localparam logic [sectorbits-1:0] idx_zero = {sectorbits{1'b0}};
  localparam logic [sectorbits-1:0] idx_one  = {{(sectorbits-1){1'b0}}, 1'b1};
  localparam logic [sectorbits-1:0] idx_last = {sectorbits{1'b1}};

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLUSH_CMD  = 3'd1,
    FLUSH_DATA = 3'd2,
    FLUSH_WAIT = 3'd3,
    FILL_CMD   = 3'd4,
    FILL_DATA  = 3'd5,
    FILL_WAIT  = 3'd6
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [sectorbits-1:0] idx_r, idx_nxt_s;
  logic                  valid_r, valid_nxt_s;
  logic                  dirty_r, dirty_nxt_s;
  logic                  sync_r, sync_nxt_s;
  logic [31:0]           tag_lba_r, tag_lba_nxt_s;
  logic [31:0]           tgt_lba_r, tgt_lba_nxt_s;
  logic [width-1:0]      fs_q_r, fs_q_nxt_s;
  logic                  blk_req_r, blk_req_nxt_s;
  logic                  blk_write_r, blk_write_nxt_s;
  logic [31:0]           blk_lba_r, blk_lba_nxt_s;
  logic [width-1:0]      blk_wr_data_r, blk_wr_data_nxt_s;
  logic [width-1:0]      sector_mem_r [depth];

  logic                  mem_we_s;
  logic [sectorbits-1:0] mem_wa_s;
  logic [width-1:0]      mem_wd_s;
  logic                  req_s, hit_s, sync_req_s;
  logic [31:0]           target_s, lba_raw_s;
  logic [sectorbits-1:0] word_idx_s;

  assign req_s      = bus.fsAccess && (bus.fsRden || bus.fsWren);
  assign word_idx_s = bus.fsAddress[sectorbits-1:0];
  assign lba_raw_s  = {{sectorbits{1'b0}}, bus.fsAddress[31:sectorbits]};
  assign target_s   = bus.fsMeta ? (lba_raw_s + METABASE) : lba_raw_s;
  assign hit_s      = valid_r && (tag_lba_r == target_s);
  assign bus.fsBusy = req_s && !((state_r == IDLE) && hit_s);

`ifdef FS_SECTOR_SYNC_EN
  assign sync_req_s = bus.fsSync;
`else
  assign sync_req_s = 1'b0;
`endif

  assign bus.fsQ       = fs_q_r;
  assign bus.blkReq    = blk_req_r;
  assign bus.blkWrite  = blk_write_r;
  assign bus.blkLba    = blk_lba_r;
  assign bus.blkWrData = blk_wr_data_r;

  // Next-state, tag update, buffer write port and requester read data.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    valid_nxt_s   = valid_r;
    dirty_nxt_s   = dirty_r;
    sync_nxt_s    = sync_r;
    tag_lba_nxt_s = tag_lba_r;
    tgt_lba_nxt_s = tgt_lba_r;
    fs_q_nxt_s    = fs_q_r;
    mem_we_s      = 1'b0;
    mem_wa_s      = word_idx_s;
    mem_wd_s      = bus.fsData;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            // A simultaneous read and write is treated as a write; fsQ holds.
            if (bus.fsWren) begin
              mem_we_s    = 1'b1;
              dirty_nxt_s = 1'b1;
            end else begin
              fs_q_nxt_s = sector_mem_r[word_idx_s];
            end
          end else begin
            tgt_lba_nxt_s = target_s;
            sync_nxt_s    = 1'b0;
            if (valid_r && dirty_r) begin
              state_nxt_s = FLUSH_CMD;
            end else begin
              state_nxt_s = FILL_CMD;
            end
          end
        end else if (sync_req_s && valid_r && dirty_r) begin
          sync_nxt_s  = 1'b1;
          state_nxt_s = FLUSH_CMD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH_CMD: begin
        if (bus.blkAck) begin
          idx_nxt_s   = idx_zero;
          state_nxt_s = FLUSH_DATA;
        end else begin
          state_nxt_s = FLUSH_CMD;
        end
      end
      FLUSH_DATA: begin
        if (bus.blkWrReady) begin
          if (idx_r == idx_last) begin
            state_nxt_s = FLUSH_WAIT;
          end else begin
            idx_nxt_s = idx_r + idx_one;
          end
        end else begin
          state_nxt_s = FLUSH_DATA;
        end
      end
      FLUSH_WAIT: begin
        if (bus.blkDone) begin
          dirty_nxt_s = 1'b0;
          sync_nxt_s  = 1'b0;
          if (sync_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = FILL_CMD;
          end
        end else begin
          state_nxt_s = FLUSH_WAIT;
        end
      end
      FILL_CMD: begin
        if (bus.blkAck) begin
          idx_nxt_s   = idx_zero;
          valid_nxt_s = 1'b0;
          state_nxt_s = FILL_DATA;
        end else begin
          state_nxt_s = FILL_CMD;
        end
      end
      FILL_DATA: begin
        if (bus.blkRdValid) begin
          mem_we_s = 1'b1;
          mem_wa_s = idx_r;
          mem_wd_s = bus.blkRdData;
          if (idx_r == idx_last) begin
            state_nxt_s = FILL_WAIT;
          end else begin
            idx_nxt_s = idx_r + idx_one;
          end
        end else begin
          state_nxt_s = FILL_DATA;
        end
      end
      FILL_WAIT: begin
        if (bus.blkDone) begin
          tag_lba_nxt_s = tgt_lba_r;
          valid_nxt_s   = 1'b1;
          dirty_nxt_s   = 1'b0;
          state_nxt_s   = IDLE;
        end else begin
          state_nxt_s = FILL_WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Block-port outputs are decoded from the next state so they leave a register.
  always_comb begin
    blk_req_nxt_s     = (state_nxt_s == FLUSH_CMD) || (state_nxt_s == FILL_CMD);
    blk_write_nxt_s   = (state_nxt_s == FLUSH_CMD);
    blk_lba_nxt_s     = 32'h0000_0000;
    blk_wr_data_nxt_s = {width{1'b0}};
    case (state_nxt_s)
      FLUSH_CMD:  blk_lba_nxt_s     = tag_lba_r;
      FILL_CMD:   blk_lba_nxt_s     = tgt_lba_nxt_s;
      FLUSH_DATA: blk_wr_data_nxt_s = sector_mem_r[idx_nxt_s];
      default:    blk_lba_nxt_s     = 32'h0000_0000;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      idx_r         <= idx_zero;
      valid_r       <= 1'b0;
      dirty_r       <= 1'b0;
      sync_r        <= 1'b0;
      tag_lba_r     <= 32'h0000_0000;
      tgt_lba_r     <= 32'h0000_0000;
      fs_q_r        <= {width{1'b0}};
      blk_req_r     <= 1'b0;
      blk_write_r   <= 1'b0;
      blk_lba_r     <= 32'h0000_0000;
      blk_wr_data_r <= {width{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      valid_r       <= valid_nxt_s;
      dirty_r       <= dirty_nxt_s;
      sync_r        <= sync_nxt_s;
      tag_lba_r     <= tag_lba_nxt_s;
      tgt_lba_r     <= tgt_lba_nxt_s;
      fs_q_r        <= fs_q_nxt_s;
      blk_req_r     <= blk_req_nxt_s;
      blk_write_r   <= blk_write_nxt_s;
      blk_lba_r     <= blk_lba_nxt_s;
      blk_wr_data_r <= blk_wr_data_nxt_s;
    end
  end

  // Sector buffer storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      sector_mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

endmodule

// File: doc/fs_sector_cache.md
# fs_sector_cache

- Sits directly downstream of the paged memory controller, on its `fs*` word-access port.
- Serves its word reads and writes, both data and `/dev/memmeta` traffic, from a single 128-word sector buffer.
- Buffer misses become whole-sector transfers on a block-device command/stream interface.
- A dirty sector is written back before it is replaced.
- `fsBusy` stalls the requester while a miss is in progress.

## Interface
Parameters:
- `width`, 32, data word width.
- `sectorbits`, 7, log2 of words per sector (128).
- `METABASE`, 32'h0010_0000, LBA offset added for metadata (`fsMeta`) accesses.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fsAccess`  in  1  requester owns the port this cycle.
- `fsRden`  in  1  word read request.
- `fsWren`  in  1  word write request.
- `fsMeta`  in  1  selects metadata region.
- `fsAddress`  in  32  word address.
- `fsData`  in  width  write data.
- `fsQ`  out  width  read data, registered.
- `fsBusy`  out  1  request cannot complete this cycle; requester holds all `fs*` inputs stable.
- `blkReq`  out  1  command valid.
- `blkWrite`  out  1  command is a sector write (1) or read (0).
- `blkLba`  out  32  command sector address.
- `blkAck`  in  1  command accepted.
- `blkWrData`  out  width  outgoing sector word.
- `blkWrReady`  in  1  device consumes `blkWrData` this cycle.
- `blkRdData`  in  width  incoming sector word.
- `blkRdValid`  in  1  `blkRdData` valid this cycle.
- `blkDone`  in  1  device finished current sector command.
- `fsSync`  in  1  write-back request. Present only with `FS_SECTOR_SYNC_EN`.

## Operation
- A request is `fsAccess && (fsRden || fsWren)`.
- Target LBA:
  - `fsAddress[31:7]` zero-extended when `fsMeta=0`.
  - `METABASE + fsAddress[31:7]` (mod 2^32) when `fsMeta=1`.
- Word index is `fsAddress[6:0]`.
- Tag state is `valid`, `dirty`, `tagLba`. A hit is `valid && tagLba == target LBA`.
- `fsBusy = request && !(state==IDLE && hit)`. It is combinational and 0 whenever there is no request.
- States:
  - IDLE:
    - Hit read: `fsQ <= buf[idx]`.
    - Hit write: `buf[idx] <= fsData`, `dirty <= 1`.
    - If `fsRden` and `fsWren` are both set, the write wins and `fsQ` holds.
    - Miss: go to FLUSH_CMD if `valid && dirty`, else FILL_CMD.
  - FLUSH_CMD: `blkReq=1`, `blkWrite=1`, `blkLba=tagLba`, held until `blkAck`. Then `idx=0`, go to FLUSH_DATA.
  - FLUSH_DATA: `blkWrData=buf[idx]`. `idx` advances on `blkWrReady`. After word 127 is consumed, go to FLUSH_WAIT.
  - FLUSH_WAIT: on `blkDone`, `dirty <= 0`, go to FILL_CMD (or IDLE for a sync flush).
  - FILL_CMD: `blkReq=1`, `blkWrite=0`, `blkLba=target LBA`, held until `blkAck`. Then `idx=0`, `valid <= 0`, go to FILL_DATA.
  - FILL_DATA: each `blkRdValid` writes `buf[idx]` and increments `idx`. After word 127, go to FILL_WAIT.
  - FILL_WAIT: on `blkDone`, `tagLba <= target`, `valid <= 1`, `dirty <= 0`, go to IDLE. The held request then hits.
- Handshake inputs are ignored outside their states:
  - `blkAck` outside *_CMD.
  - `blkWrReady` outside FLUSH_DATA.
  - `blkRdValid` outside FILL_DATA.
  - `blkDone` outside *_WAIT.
- The `idx` counter is 7 bits. The terminal condition is `idx==127` with a handshake; no wrap occurs.
- The target LBA is sampled into a register on leaving IDLE. Changing the request mid-miss is a protocol violation, and the fill completes to the sampled LBA.
- Reset mid-operation: state IDLE, `valid=0`, `dirty=0`. Dirty buffer contents are lost. Any block command in flight is abandoned, so the device must also be reset.

## Timing
- Reset values:
  - `fsQ=0`, `blkReq=0`, `blkWrite=0`, `blkLba=0`, `blkWrData=0`.
  - `fsBusy=0` while no request.
- Hit read latency: request at edge N with `fsBusy=0` gives `fsQ` valid after edge N, held until the next read.
- Hit write: buffer updated at the same edge.
- `blkReq` rises the cycle after the miss edge and falls the cycle after `blkAck`.
- Clean-miss minimum latency, with `blkAck` immediate and one word per cycle: 1 (cmd) + 128 (data) + 1 (done) + 1 = hit after ~131 cycles.
- A dirty miss adds about 130 cycles.

## Configuration
- `FS_SECTOR_SYNC_EN`:
  - Defined:
    - Adds `fsSync`.
    - A `fsSync` pulse sampled in IDLE with no request and `valid && dirty` runs FLUSH_CMD, FLUSH_DATA, FLUSH_WAIT, then IDLE.
    - Afterwards `valid` stays 1 and `dirty` is 0.
    - A request during a sync flush sees `fsBusy=1`.
    - If `fsSync` and a request coincide, the request wins and the sync is dropped.
  - Undefined: no port; dirty data is written back only on eviction.

## Test plan
- Cold read of 0x0000_0085, device returns word n = 0xA000_0000+n → FILL_CMD with `blkLba=1`. After `blkDone`, `fsBusy` falls and `fsQ=0xA000_0005` one edge later.
- Hit write of 0xDEAD_BEEF to 0x0000_0081, then read of 0x81 → no `blkReq`, `fsQ=0xDEAD_BEEF`, `dirty=1`.
- Miss to 0x0000_0200 with the dirty sector from the previous test → write to LBA 1 first, streamed word 1 = 0xDEAD_BEEF, then a read of LBA 4.
- Metadata read `fsMeta=1`, address 0x3 → `blkLba=0x0010_0000`.
- `blkWrReady` toggling every other cycle → exactly 128 words, in order, no duplicates.
- `rst_n` pulled low mid-FILL_DATA → `blkReq=0`, `fsQ=0`. The next request issues a fresh fill.
- With `FS_SECTOR_SYNC_EN`, `fsSync` after a write → write to LBA 1. A subsequent same-sector read hits with no `blkReq`.
